// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter_pkg
//  Brief    : Shared types and constants for the unified memory-port arbiter
//             (requester ownership, arbiter state, full byte-enable mask).
//  Revision : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    // Which requester owns the outstanding memory transaction
    typedef enum logic [0:0] {
        OWNER_INSTR = 1'b0,
        OWNER_DATA  = 1'b1
    } mem_owner_t;

    // Arbiter top-level state
    typedef enum logic [0:0] {
        ARB_IDLE     = 1'b0,
        ARB_WAIT_RSP = 1'b1
    } arb_state_t;

    // Instruction fetches always read a whole word
    localparam logic [3:0] MEM_BE_FULL = 4'hF;

endpackage : mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter_watchdog.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter_watchdog
//  Brief    : Response watchdog. Cleared when a transaction is accepted,
//             counts while a response is awaited, and flags the last allowed
//             waiting cycle so the arbiter can force an error response.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    // Last waiting cycle index; the count starts at 0 in the first wait cycle
    localparam logic [7:0] c_last = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_count;

    // Cycle counter: clear on a new grant, advance while waiting
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= 8'd0;
        end else if (i_enable) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_terminal = (r_count == c_last);

endmodule : mem_port_arbiter_watchdog
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Brief    : Shares one memory port between instruction fetch and data
//             access. Data has priority unless instruction has been starved
//             for MAX_STARVE consecutive data grants. One transaction is
//             outstanding at a time; a hung response becomes an error reply.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned MAX_STARVE     = 4
) (
    input  logic        clk,
    input  logic        reset,
    // instruction requester
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    // data requester
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_gnt,
    output logic        d_rvalid,
    // shared response
    output logic [31:0] rdata,
    output logic        rsp_err,
    // memory side
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_be,
    input  logic        m_ready,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata,
    // status
    output logic        busy
);

    localparam logic [3:0] c_max_starve = 4'(MAX_STARVE);

    arb_state_t r_state;
    mem_owner_t r_owner;
    logic [3:0] r_starve_cnt;

    logic w_idle;
    logic w_wait;
    logic w_data_wins;
    logic w_instr_wins;
    logic w_accept;
    logic w_timeout;
    logic w_rsp;

    // Outputs are forced quiet while reset is asserted
    assign w_idle = (r_state == ARB_IDLE)     && !reset;
    assign w_wait = (r_state == ARB_WAIT_RSP) && !reset;

    // Data wins unless instruction is waiting and has been starved enough
    assign w_data_wins  = d_req && (!i_req || (r_starve_cnt < c_max_starve));
    assign w_instr_wins = i_req && !w_data_wins;

    assign m_req    = w_idle && (i_req || d_req);
    assign w_accept = m_req && m_ready;

    assign i_gnt = w_accept && w_instr_wins;
    assign d_gnt = w_accept && w_data_wins;

    // A real response beats a coincident timeout
    assign w_rsp    = w_wait && (m_rvalid || w_timeout);
    assign i_rvalid = w_rsp && (r_owner == OWNER_INSTR);
    assign d_rvalid = w_rsp && (r_owner == OWNER_DATA);
    assign rdata    = (w_wait && m_rvalid) ? m_rdata : 32'd0;
    assign rsp_err  = w_rsp && !m_rvalid;
    assign busy     = w_wait;

    // Memory request fields steered from the current arbitration winner
    always_comb begin
        m_we    = 1'b0;
        m_addr  = 32'd0;
        m_wdata = 32'd0;
        m_be    = 4'd0;
        if (w_idle && w_data_wins) begin
            m_we    = d_we;
            m_addr  = d_addr;
            m_wdata = d_wdata;
            m_be    = d_be;
        end else if (w_idle && w_instr_wins) begin
            m_addr  = i_addr;
            m_be    = MEM_BE_FULL;
        end
    end

    // Arbiter state, transaction owner and starvation tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ARB_IDLE;
            r_owner      <= OWNER_INSTR;
            r_starve_cnt <= 4'd0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_accept) begin
                        r_state <= ARB_WAIT_RSP;
                        r_owner <= w_data_wins ? OWNER_DATA : OWNER_INSTR;
                    end
                    // No pending fetch means nobody is being starved
                    if (!i_req) begin
                        r_starve_cnt <= 4'd0;
                    end else if (w_accept && w_instr_wins) begin
                        r_starve_cnt <= 4'd0;
                    end else if (w_accept && w_data_wins &&
                                 (r_starve_cnt < c_max_starve)) begin
                        r_starve_cnt <= r_starve_cnt + 4'd1;
                    end
                end
                ARB_WAIT_RSP: begin
                    if (m_rvalid || w_timeout) begin
                        r_state <= ARB_IDLE;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    mem_port_arbiter_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_accept),
        .i_enable   (r_state == ARB_WAIT_RSP),
        .o_terminal (w_timeout)
    );

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Brief    : Self-checking bench for mem_port_arbiter: directed scenarios
//             with literal expectations followed by randomized traffic
//             compared against a transaction-level model every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int TMO = 16;
    localparam int MS  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we, m_ready, m_rvalid;
    logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
    logic [3:0]  d_be;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, rsp_err, m_req, m_we, busy;
    logic [31:0] rdata, m_addr, m_wdata;
    logic [3:0]  m_be;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .TIMEOUT_CYCLES (TMO),
        .MAX_STARVE     (MS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_be     (d_be),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .rdata    (rdata),
        .rsp_err  (rsp_err),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_be     (m_be),
        .m_ready  (m_ready),
        .m_rvalid (m_rvalid),
        .m_rdata  (m_rdata),
        .busy     (busy)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Transaction-level model: is a transaction open, who owns it, how long
    // it has been waiting, and how many data grants skipped a pending fetch.
    bit md_busy    = 0;
    bit md_own_d   = 0;
    int md_age     = 0;
    int md_starve  = 0;

    logic        e_i_gnt = 0, e_d_gnt = 0, e_i_rv = 0, e_d_rv = 0, e_err = 0;
    logic        e_mreq = 0, e_mwe = 0, e_busy = 0;
    logic [31:0] e_rdata = 0, e_maddr = 0, e_mwdata = 0;
    logic [3:0]  e_mbe = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Mid-cycle: derive expected outputs from the model and compare
    task automatic settle();
        bit dw, iw, acc;
        @(negedge clk);
        e_i_gnt = 0; e_d_gnt = 0; e_i_rv = 0; e_d_rv = 0; e_err = 0;
        e_mreq = 0; e_mwe = 0; e_busy = 0; e_rdata = 0; e_maddr = 0;
        e_mwdata = 0; e_mbe = 0;
        if (!reset && !md_busy) begin
            dw = d_req && (!i_req || md_starve < MS);
            iw = i_req && !dw;
            e_mreq = i_req || d_req;
            if (dw) begin
                e_mwe = d_we; e_maddr = d_addr; e_mwdata = d_wdata; e_mbe = d_be;
            end else if (iw) begin
                e_maddr = i_addr; e_mbe = 4'hF;
            end
            acc = e_mreq && m_ready;
            e_d_gnt = acc && dw;
            e_i_gnt = acc && iw;
        end else if (!reset) begin
            e_busy = 1;
            if (m_rvalid || md_age == TMO - 1) begin
                if (md_own_d) e_d_rv = 1; else e_i_rv = 1;
                e_err   = !m_rvalid;
                e_rdata = m_rvalid ? m_rdata : 32'd0;
            end
        end
        chk("i_gnt",    i_gnt,    e_i_gnt);
        chk("d_gnt",    d_gnt,    e_d_gnt);
        chk("i_rvalid", i_rvalid, e_i_rv);
        chk("d_rvalid", d_rvalid, e_d_rv);
        chk("rsp_err",  rsp_err,  e_err);
        chk("rdata",    rdata,    e_rdata);
        chk("m_req",    m_req,    e_mreq);
        chk("m_we",     m_we,     e_mwe);
        chk("m_addr",   m_addr,   e_maddr);
        chk("m_wdata",  m_wdata,  e_mwdata);
        chk("m_be",     m_be,     e_mbe);
        chk("busy",     busy,     e_busy);
    endtask

    // Clock edge: advance the model with the inputs seen this cycle
    task automatic adv();
        @(posedge clk);
        if (reset) begin
            md_busy = 0; md_own_d = 0; md_starve = 0; md_age = 0;
        end else if (!md_busy) begin
            if (!i_req) md_starve = 0;
            if (e_i_gnt) begin
                md_busy = 1; md_age = 0; md_own_d = 0; md_starve = 0;
            end
            if (e_d_gnt) begin
                md_busy = 1; md_age = 0; md_own_d = 1;
                if (i_req && md_starve < MS) md_starve++;
            end
        end else begin
            if (e_i_rv || e_d_rv) md_busy = 0;
            else md_age++;
        end
        #1;
    endtask

    task automatic quiet();
        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        d_be = 0; m_ready = 0; m_rvalid = 0; m_rdata = 0;
    endtask

    initial begin
        int rsp_pct;
        reset = 1;
        quiet();
        // ---------------- reset ----------------
        settle();
        chk("rst_mreq", m_req, 0);
        chk("rst_busy", busy, 0);
        adv();
        reset = 0;
        settle();
        chk("idle_mreq", m_req, 0);
        adv();

        // ---------------- lone fetch ----------------
        i_req = 1; i_addr = 32'h10; m_ready = 1;
        settle();
        chk("lone_gnt", i_gnt, 1);
        chk("lone_be", m_be, 32'hF);
        chk("lone_we", m_we, 0);
        chk("lone_addr", m_addr, 32'h10);
        adv();
        i_req = 0;
        settle();
        chk("lone_busy1", busy, 1);
        chk("lone_norv", i_rvalid, 0);
        adv();
        m_rvalid = 1; m_rdata = 32'h93;
        settle();
        chk("lone_busy2", busy, 1);
        chk("lone_rv", i_rvalid, 1);
        chk("lone_rdata", rdata, 32'h93);
        chk("lone_err", rsp_err, 0);
        adv();
        m_rvalid = 0;
        settle();
        chk("lone_done", busy, 0);
        adv();

        // ---------------- contention ----------------
        i_req = 1; i_addr = 32'h14;
        d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_be = 4'h3;
        settle();
        chk("cont_dgnt", d_gnt, 1);
        chk("cont_igntlo", i_gnt, 0);
        chk("cont_we", m_we, 1);
        chk("cont_be", m_be, 32'h3);
        chk("cont_wdata", m_wdata, 32'hDEADBEEF);
        adv();
        d_req = 0;
        settle();
        adv();
        m_rvalid = 1;
        settle();
        chk("cont_drv", d_rvalid, 1);
        chk("cont_igntwait", i_gnt, 0);
        adv();
        m_rvalid = 0;
        settle();
        chk("cont_igntafter", i_gnt, 1);
        adv();
        i_req = 0; m_rvalid = 1; m_rdata = 32'h13;
        settle();
        chk("cont_irv", i_rvalid, 1);
        adv();
        m_rvalid = 0;

        // ---------------- starvation ----------------
        for (int g = 0; g < 6; g++) begin
            i_req = 1; d_req = 1; d_we = 0; d_addr = 32'h200 + g; m_ready = 1;
            settle();
            chk("starve_dgnt", d_gnt, (g != 4));
            chk("starve_ignt", i_gnt, (g == 4));
            adv();
            if (g != 4) d_req = 0;
            m_rvalid = 1;
            settle();
            adv();
            m_rvalid = 0;
        end
        quiet();

        // ---------------- backpressure ----------------
        d_req = 1; d_addr = 32'h300; d_be = 4'hF;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("bp_mreq", m_req, 1);
            chk("bp_addr", m_addr, 32'h300);
            chk("bp_nognt", d_gnt, 0);
            adv();
        end
        m_ready = 1;
        settle();
        chk("bp_gnt", d_gnt, 1);
        adv();
        d_req = 0; m_rvalid = 1;
        settle();
        adv();
        m_rvalid = 0;

        // ---------------- timeout ----------------
        d_req = 1; d_addr = 32'h400;
        settle();
        chk("tmo_gnt", d_gnt, 1);
        adv();
        d_req = 0;
        for (int k = 1; k <= TMO; k++) begin
            settle();
            chk("tmo_rv", d_rvalid, (k == TMO));
            if (k == TMO) begin
                chk("tmo_err", rsp_err, 1);
                chk("tmo_rdata", rdata, 0);
            end
            adv();
        end
        m_rvalid = 1; m_rdata = 32'h55;
        settle();
        chk("late_drv", d_rvalid, 0);
        chk("late_irv", i_rvalid, 0);
        chk("late_rdata", rdata, 0);
        adv();
        m_rvalid = 0;

        // ---------------- reset mid-transaction ----------------
        i_req = 1; i_addr = 32'h18;
        settle();
        chk("rmid_gnt", i_gnt, 1);
        adv();
        i_req = 0;
        settle();
        adv();
        reset = 1;
        settle();
        chk("rmid_busy", busy, 0);
        adv();
        reset = 0; m_rvalid = 1; m_rdata = 32'h77;
        settle();
        chk("rmid_irv", i_rvalid, 0);
        chk("rmid_drv", d_rvalid, 0);
        chk("rmid_busy2", busy, 0);
        adv();
        m_rvalid = 0; i_req = 1; i_addr = 32'h20;
        settle();
        chk("rmid_regnt", i_gnt, 1);
        chk("rmid_addr", m_addr, 32'h20);
        adv();
        i_req = 0; m_rvalid = 1; m_rdata = 32'h13;
        settle();
        chk("rmid_rv", i_rvalid, 1);
        chk("rmid_rdata", rdata, 32'h13);
        adv();
        quiet();

        // ---------------- randomized traffic ----------------
        for (int blk = 0; blk < 10; blk++) begin
            rsp_pct = (blk % 2 == 1) ? 40 : 6;
            for (int c = 0; c < 200; c++) begin
                reset = ($urandom_range(0, 199) == 0);
                if (!i_req || e_i_gnt) begin
                    i_req  = $urandom_range(0, 1);
                    i_addr = $urandom() & 32'hFFFF_FFFC;
                end
                if (!d_req || e_d_gnt) begin
                    d_req   = $urandom_range(0, 1);
                    d_we    = $urandom_range(0, 1);
                    d_addr  = $urandom();
                    d_wdata = $urandom();
                    d_be    = 4'($urandom_range(0, 15));
                end
                m_ready  = ($urandom_range(0, 99) < 70);
                m_rvalid = ($urandom_range(0, 99) < rsp_pct);
                m_rdata  = $urandom();
                settle();
                adv();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire
